// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store wins by default; a starved fetch gains priority after MAX_WAIT denials.
module mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [DATA_W-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic {
      PRIO_LS = 1'b0,
      PRIO_IF = 1'b1
   } prio_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_e;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   prio_e      state_q, state_d;
   owner_e     owner_q, owner_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       if_gnt_s, ls_gnt_s;

   // Grant selection; grants are held off while reset is asserted
   always_comb begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
      if (!rst) begin
         if_gnt_s = 1'b0;
         ls_gnt_s = 1'b0;
      end else begin
         case (state_q)
            PRIO_LS: begin
               if (ls_req_i) begin
                  ls_gnt_s = 1'b1;
               end else if (if_req_i) begin
                  if_gnt_s = 1'b1;
               end else begin
                  ls_gnt_s = 1'b0;
               end
            end
            PRIO_IF: begin
               if (if_req_i) begin
                  if_gnt_s = 1'b1;
               end else if (ls_req_i) begin
                  ls_gnt_s = 1'b1;
               end else begin
                  if_gnt_s = 1'b0;
               end
            end
            default: begin
               if_gnt_s = 1'b0;
               ls_gnt_s = 1'b0;
            end
         endcase
      end
   end

   // Starvation counter, priority next state and read-owner next state
   always_comb begin
      wait_cnt_d = 4'd0;
      state_d    = state_q;
      owner_d    = OWN_NONE;

      if (if_req_i && !if_gnt_s) begin
         if (wait_cnt_q >= MAX_WAIT_C) begin
            wait_cnt_d = MAX_WAIT_C;
         end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end
      end else begin
         wait_cnt_d = 4'd0;
      end

      case (state_q)
         PRIO_LS: begin
            if (wait_cnt_d == MAX_WAIT_C) begin
               state_d = PRIO_IF;
            end else begin
               state_d = PRIO_LS;
            end
         end
         PRIO_IF: begin
            if (if_gnt_s || !if_req_i) begin
               state_d = PRIO_LS;
            end else begin
               state_d = PRIO_IF;
            end
         end
         default: state_d = PRIO_LS;
      endcase

      if (if_gnt_s) begin
         owner_d = OWN_IF;
      end else if (ls_gnt_s && !ls_we_i) begin
         owner_d = OWN_LS;
      end else begin
         owner_d = OWN_NONE;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= PRIO_LS;
         wait_cnt_q <= 4'd0;
         owner_q    <= OWN_NONE;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         owner_q    <= owner_d;
      end
   end

   // Memory port drive and response routing; idle port is driven to zero
   always_comb begin
      mem_ce_o    = if_gnt_s | ls_gnt_s;
      mem_we_o    = ls_gnt_s & ls_we_i;
      mem_addr_o  = {ADDR_W{1'b0}};
      mem_wdata_o = {DATA_W{1'b0}};
      if (if_gnt_s) begin
         mem_addr_o  = if_addr_i;
         mem_wdata_o = ls_wdata_i;
      end else if (ls_gnt_s) begin
         mem_addr_o  = ls_addr_i;
         mem_wdata_o = ls_wdata_i;
      end else begin
         mem_addr_o  = {ADDR_W{1'b0}};
         mem_wdata_o = {DATA_W{1'b0}};
      end

      if_rvalid_o = (owner_q == OWN_IF);
      ls_rvalid_o = (owner_q == OWN_LS);
      if_rdata_o  = if_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};
      ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};
   end

   assign if_gnt_o = if_gnt_s;
   assign ls_gnt_o = ls_gnt_s;

endmodule
